// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with a multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO engine
// and a combinational forwarding read port.
module hilo_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             op_valid,
  input  logic [2:0]                       op,
  input  logic [DATA_WIDTH-1:0]            op_a,
  input  logic [DATA_WIDTH-1:0]            op_b,
  input  logic                             flush,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            res_hi,
  output logic [DATA_WIDTH-1:0]            res_lo,
  output logic                             res_hi_we,
  output logic                             res_lo_we,
  input  logic [FWD_STAGES-1:0]            fwd_hi_we,
  input  logic [FWD_STAGES-1:0]            fwd_lo_we,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_hi,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_lo,
  input  logic                             wb_hi_we,
  input  logic                             wb_lo_we,
  input  logic [DATA_WIDTH-1:0]            wb_hi,
  input  logic [DATA_WIDTH-1:0]            wb_lo,
  output logic [DATA_WIDTH-1:0]            hi_o,
  output logic [DATA_WIDTH-1:0]            lo_o
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
  logic [DATA_WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic                  is_signed_q, is_signed_d, res_hi_we_q, res_hi_we_d, res_lo_we_q, res_lo_we_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   b_mag, step_rem, step_quo;
  logic [DATA_WIDTH:0]     rem_shift, diff;
  logic [2*DATA_WIDTH-1:0] ext_a, ext_b, product;
  logic                    neg_q, neg_r;

  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v, input logic s);
    return (s && v[DATA_WIDTH-1]) ? -v : v;
  endfunction

  assign accept = op_valid && (op <= 3'b101) && !flush && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      is_signed_q <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_hi_we_q <= 1'b0;
      res_lo_we_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      is_signed_q <= is_signed_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_hi_we_q <= res_hi_we_d;
      res_lo_we_q <= res_lo_we_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Flush wins over accept; accept only happens from IDLE or DONE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      if (op[2:1] == 2'b00)      state_d = MUL;
      else if (op[2:1] == 2'b01) state_d = DIV;
      else                       state_d = DONE;
    end else begin
      case (state_q)
        MUL:     state_d = DONE;
        DIV:     if (cnt_q == CW'(1)) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == MUL) || (state_q == DIV);
    done = (state_q == DONE);
  end

  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign res_hi_we = res_hi_we_q;
  assign res_lo_we = res_lo_we_q;

  // Restoring divide: dividend magnitude shifts out of quo_q while quotient bits shift in.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    is_signed_d = is_signed_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_hi_we_d = res_hi_we_q;
    res_lo_we_d = res_lo_we_q;
    hi_d        = wb_hi_we ? wb_hi : hi_q;
    lo_d        = wb_lo_we ? wb_lo : lo_q;

    b_mag     = mag(b_q, is_signed_q);
    rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    diff      = rem_shift - {1'b0, b_mag};
    step_rem  = diff[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    step_quo  = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    neg_q     = is_signed_q && (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
    neg_r     = is_signed_q && a_q[DATA_WIDTH-1];
    ext_a     = {{DATA_WIDTH{is_signed_q && a_q[DATA_WIDTH-1]}}, a_q};
    ext_b     = {{DATA_WIDTH{is_signed_q && b_q[DATA_WIDTH-1]}}, b_q};
    product   = ext_a * ext_b;

    if (accept) begin
      a_d         = op_a;
      b_d         = op_b;
      is_signed_d = ~op[0];
      rem_d       = '0;
      quo_d       = mag(op_a, ~op[0]);
      cnt_d       = CW'(DATA_WIDTH);
      if (op == 3'b100) begin
        res_hi_d    = op_a;
        res_hi_we_d = 1'b1;
        res_lo_we_d = 1'b0;
      end else if (op == 3'b101) begin
        res_lo_d    = op_a;
        res_hi_we_d = 1'b0;
        res_lo_we_d = 1'b1;
      end
    end else if (!flush) begin
      if (state_q == MUL) begin
        res_hi_d    = product[2*DATA_WIDTH-1:DATA_WIDTH];
        res_lo_d    = product[DATA_WIDTH-1:0];
        res_hi_we_d = 1'b1;
        res_lo_we_d = 1'b1;
      end else if (state_q == DIV) begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_hi_we_d = 1'b1;
          res_lo_we_d = 1'b1;
          if (b_q == '0) begin
            res_lo_d = '1;
            res_hi_d = a_q;
          end else if (is_signed_q && a_q == MOST_NEG && b_q == '1) begin
            res_lo_d = MOST_NEG;
            res_hi_d = '0;
          end else begin
            res_lo_d = neg_q ? -step_quo : step_quo;
            res_hi_d = neg_r ? -step_rem : step_rem;
          end
        end
      end
    end
  end

  // Youngest stage wins, so scan from the oldest and let lower indices overwrite.
  always_comb begin
    hi_o = wb_hi_we ? wb_hi : hi_q;
    lo_o = wb_lo_we ? wb_lo : lo_q;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (fwd_hi_we[i]) hi_o = fwd_hi[i*DATA_WIDTH +: DATA_WIDTH];
      if (fwd_lo_we[i]) lo_o = fwd_lo[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule
